// File: rtl/program_memory_pkg.sv
// Shared definitions for the program memory: FSM encodings, default NOP word, opcode fields.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package program_memory_pkg;

  typedef enum logic [1:0] {
    st_empty = 2'd0,
    st_load  = 2'd1,
    st_run   = 2'd2
  } pm_state_t;

  // Word handed back for unprogrammed or out-of-range addresses.
  localparam logic [15:0] pm_nop_default = 16'h0000;

  // Opcode field (top nibble of a 16-bit instruction word).
  localparam logic [3:0] op_jump = 4'h8;
  localparam logic [3:0] op_ldi  = 4'hA;
  localparam logic [3:0] op_add  = 4'hB;
  localparam logic [3:0] op_rep  = 4'hC;
  localparam logic [3:0] op_sub  = 4'hD;
  localparam logic [3:0] op_out  = 4'hE;
  localparam logic [3:0] op_halt = 4'hF;

  // Pack an opcode and a 12-bit operand field into one instruction word.
  function automatic logic [15:0] make_instr(input logic [3:0] op, input logic [11:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/pm_ram.sv
// Single-port RAM, DEPTH x DATA_W, synchronous write and synchronous read.
// Latency: read data appears the cycle after re; write lands on the same edge.
// Backpressure: none; callers never assert we and re together.
module pm_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is intentionally not reset; rdata only moves on a read so it holds between fetches.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/program_memory.sv
// Program store: a loader streams words in (EMPTY/LOAD), then fetches read them back (RUN).
// Latency: fetch_valid/instr/fault one cycle after an accepted fetch_req.
// Backpressure: load_ready low in RUN; fetches are never stalled (one per cycle).
module program_memory
  import program_memory_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(pm_nop_default)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              load_clear,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault,
  output logic              running,
  output logic [ADDR_W:0]   prog_len
);

  localparam int              ram_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] depth_x   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ram_aw-1:0] last_addr = ram_aw'(DEPTH - 1);

  pm_state_t         state;
  logic [ram_aw-1:0] wr_ptr;
  logic              hit_q;       // last accepted fetch landed inside the program
  logic [ADDR_W:0]   addr_x;
  logic              in_prog;
  logic              out_range;
  logic              load_acc;
  logic              fetch_acc;
  logic              ram_we;
  logic              ram_re;
  logic [ram_aw-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  // Range checks and acceptance; load_clear overrides both a load and a fetch.
  always_comb begin
    addr_x    = {1'b0, fetch_addr};
    in_prog   = addr_x < prog_len;
    out_range = addr_x >= depth_x;
    load_acc  = load_valid & load_ready & ~load_clear;
    fetch_acc = fetch_req & (state == st_run) & ~load_clear;
    ram_we    = load_acc;
    ram_re    = fetch_acc & in_prog;
    ram_addr  = ram_we ? wr_ptr : fetch_addr[ram_aw-1:0];
  end

  // Loading and fetching never overlap (load_ready is low in RUN), so one port suffices.
  pm_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (ram_aw)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  // Misses and faults read as NOP; between fetches both hit_q and ram_rdata hold.
  assign fetch_instr = hit_q ? ram_rdata : NOP_WORD;

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= st_empty;
      wr_ptr      <= '0;
      prog_len    <= '0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      hit_q       <= 1'b0;
      running     <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      if (load_clear) begin
        state      <= st_empty;
        wr_ptr     <= '0;
        prog_len   <= '0;
        running    <= 1'b0;
        load_ready <= 1'b1;
      end else begin
        unique case (state)
          st_empty, st_load: begin
            if (load_acc) begin
              wr_ptr   <= wr_ptr + ram_aw'(1);
              prog_len <= prog_len + (ADDR_W + 1)'(1);
              // The final storage word ends the load even without load_last.
              if (load_last || (wr_ptr == last_addr)) begin
                state      <= st_run;
                running    <= 1'b1;
                load_ready <= 1'b0;
              end else begin
                state <= st_load;
              end
            end
          end
          st_run: begin
            if (fetch_acc) begin
              fetch_valid <= 1'b1;
              fetch_fault <= out_range;
              hit_q       <= in_prog;
            end
          end
          default: begin
            state      <= st_empty;
            running    <= 1'b0;
            load_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: a default-size instance and a DEPTH=4 instance.
// Latency: checks sample #1 after the rising edge that registers a result.
// Backpressure: load_ready is checked per cycle while streaming into the small instance.
module tb_program_memory;
  import program_memory_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] prog [0:10];

  // main instance (DEPTH 1024)
  logic        a_load_valid = 0, a_load_last = 0, a_load_clear = 0, a_fetch_req = 0;
  logic [15:0] a_load_data = '0, a_fetch_addr = '0;
  logic        a_load_ready, a_fetch_valid, a_fetch_fault, a_running;
  logic [15:0] a_fetch_instr;
  logic [16:0] a_prog_len;

  // small instance (DEPTH 4)
  logic        b_load_valid = 0, b_load_last = 0, b_load_clear = 0, b_fetch_req = 0;
  logic [15:0] b_load_data = '0, b_fetch_addr = '0;
  logic        b_load_ready, b_fetch_valid, b_fetch_fault, b_running;
  logic [15:0] b_fetch_instr;
  logic [16:0] b_prog_len;

  program_memory dut_a (
    .clk(clk), .rst(rst),
    .load_valid(a_load_valid), .load_data(a_load_data), .load_last(a_load_last),
    .load_ready(a_load_ready), .load_clear(a_load_clear),
    .fetch_req(a_fetch_req), .fetch_addr(a_fetch_addr),
    .fetch_valid(a_fetch_valid), .fetch_instr(a_fetch_instr), .fetch_fault(a_fetch_fault),
    .running(a_running), .prog_len(a_prog_len)
  );

  program_memory #(.DEPTH(4)) dut_b (
    .clk(clk), .rst(rst),
    .load_valid(b_load_valid), .load_data(b_load_data), .load_last(b_load_last),
    .load_ready(b_load_ready), .load_clear(b_load_clear),
    .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr),
    .fetch_valid(b_fetch_valid), .fetch_instr(b_fetch_instr), .fetch_fault(b_fetch_fault),
    .running(b_running), .prog_len(b_prog_len)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [15:0] d, input logic last);
    a_load_valid = 1'b1; a_load_data = d; a_load_last = last;
    step();
    a_load_valid = 1'b0; a_load_last = 1'b0;
  endtask

  task automatic fetch_a(input logic [15:0] addr);
    a_fetch_req = 1'b1; a_fetch_addr = addr;
    step();
    a_fetch_req = 1'b0;
  endtask

  task automatic fetch_b(input logic [15:0] addr);
    b_fetch_req = 1'b1; b_fetch_addr = addr;
    step();
    b_fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (a_load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b exp 1", a_load_ready); end
    checks++; if (a_running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", a_running); end
    checks++; if (a_prog_len !== 17'd0) begin errors++; $display("FAIL reset_prog_len got %0d exp 0", a_prog_len); end
    checks++; if (a_fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got %b exp 0", a_fetch_valid); end
    checks++; if (a_fetch_instr !== 16'h0000) begin errors++; $display("FAIL reset_fetch_instr got %h exp 0000", a_fetch_instr); end
    checks++; if (a_fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fetch_fault got %b exp 0", a_fetch_fault); end
    checks++; if (b_load_ready !== 1'b1) begin errors++; $display("FAIL reset_b_load_ready got %b exp 1", b_load_ready); end
  endtask

  task automatic test_load_program();
    for (int i = 0; i < 11; i++) begin
      load_a(prog[i], (i == 10));
      if (i == 9) begin
        checks++; if (a_running !== 1'b0 || a_load_ready !== 1'b1) begin
          errors++; $display("FAIL load_pre_last running=%b ready=%b exp running=0 ready=1", a_running, a_load_ready);
        end
      end
    end
    checks++; if (a_prog_len !== 17'd11) begin errors++; $display("FAIL load_prog_len got %0d exp 11", a_prog_len); end
    checks++; if (a_running !== 1'b1) begin errors++; $display("FAIL load_running got %b exp 1", a_running); end
    checks++; if (a_load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_in_run got %b exp 0", a_load_ready); end
  endtask

  task automatic test_fetch();
    fetch_a(16'd0);
    checks++; if (a_fetch_valid !== 1'b1 || a_fetch_instr !== 16'hA407 || a_fetch_fault !== 1'b0) begin
      errors++; $display("FAIL fetch0 got v=%b i=%h f=%b exp v=1 i=a407 f=0", a_fetch_valid, a_fetch_instr, a_fetch_fault);
    end
    step();
    checks++; if (a_fetch_valid !== 1'b0 || a_fetch_instr !== 16'hA407) begin
      errors++; $display("FAIL fetch_hold got v=%b i=%h exp v=0 i=a407", a_fetch_valid, a_fetch_instr);
    end
    fetch_a(16'd5);
    checks++; if (a_fetch_valid !== 1'b1 || a_fetch_instr !== 16'hC404 || a_fetch_fault !== 1'b0) begin
      errors++; $display("FAIL fetch5 got v=%b i=%h f=%b exp v=1 i=c404 f=0", a_fetch_valid, a_fetch_instr, a_fetch_fault);
    end
  endtask

  task automatic test_range();
    fetch_a(16'd11);
    checks++; if (a_fetch_valid !== 1'b1 || a_fetch_instr !== 16'h0000 || a_fetch_fault !== 1'b0) begin
      errors++; $display("FAIL fetch_past_prog got v=%b i=%h f=%b exp v=1 i=0000 f=0", a_fetch_valid, a_fetch_instr, a_fetch_fault);
    end
    fetch_a(16'd1024);
    checks++; if (a_fetch_valid !== 1'b1 || a_fetch_instr !== 16'h0000 || a_fetch_fault !== 1'b1) begin
      errors++; $display("FAIL fetch_depth got v=%b i=%h f=%b exp v=1 i=0000 f=1", a_fetch_valid, a_fetch_instr, a_fetch_fault);
    end
    step();
    checks++; if (a_fetch_valid !== 1'b0 || a_fetch_fault !== 1'b0) begin
      errors++; $display("FAIL fault_idle got v=%b f=%b exp v=0 f=0", a_fetch_valid, a_fetch_fault);
    end
  endtask

  task automatic test_back_to_back();
    a_fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_fetch_addr = 16'(i);
      step();
      checks++; if (a_fetch_valid !== 1'b1 || a_fetch_instr !== prog[i]) begin
        errors++; $display("FAIL b2b_%0d got v=%b i=%h exp v=1 i=%h", i, a_fetch_valid, a_fetch_instr, prog[i]);
      end
    end
    a_fetch_req = 1'b0;
    step();
    checks++; if (a_fetch_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got v=%b exp 0", a_fetch_valid); end
  endtask

  task automatic test_reset_mid_load();
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int i = 0; i < 3; i++) load_a(prog[i], 1'b0);
    checks++; if (a_prog_len !== 17'd3) begin errors++; $display("FAIL partial_len got %0d exp 3", a_prog_len); end
    rst = 1'b1;
    #1;
    checks++; if (a_prog_len !== 17'd0 || a_running !== 1'b0 || a_load_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got len=%0d run=%b rdy=%b exp 0 0 1", a_prog_len, a_running, a_load_ready);
    end
    step();
    rst = 1'b0;
    fetch_a(16'd0);
    checks++; if (a_fetch_valid !== 1'b0 || a_fetch_instr !== 16'h0000) begin
      errors++; $display("FAIL fetch_in_empty got v=%b i=%h exp v=0 i=0000", a_fetch_valid, a_fetch_instr);
    end
    // fetch_req during LOAD is ignored while the load proceeds
    a_fetch_req = 1'b1; a_fetch_addr = 16'd0;
    load_a(16'h1111, 1'b0);
    a_fetch_req = 1'b1;
    load_a(16'h2222, 1'b1);
    a_fetch_req = 1'b0;
    checks++; if (a_fetch_valid !== 1'b0) begin errors++; $display("FAIL fetch_in_load got v=%b exp 0", a_fetch_valid); end
    checks++; if (a_prog_len !== 17'd2 || a_running !== 1'b1) begin
      errors++; $display("FAIL reload_len got len=%0d run=%b exp 2 1", a_prog_len, a_running);
    end
    fetch_a(16'd0);
    checks++; if (a_fetch_instr !== 16'h1111) begin errors++; $display("FAIL restart_addr0 got %h exp 1111", a_fetch_instr); end
    fetch_a(16'd1);
    checks++; if (a_fetch_instr !== 16'h2222) begin errors++; $display("FAIL restart_addr1 got %h exp 2222", a_fetch_instr); end
  endtask

  task automatic test_clear();
    a_load_clear = 1'b1; a_fetch_req = 1'b1; a_fetch_addr = 16'd0;
    a_load_valid = 1'b1; a_load_data = 16'hDEAD;
    step();
    a_load_clear = 1'b0; a_fetch_req = 1'b0; a_load_valid = 1'b0;
    checks++; if (a_fetch_valid !== 1'b0) begin errors++; $display("FAIL clear_fetch got v=%b exp 0", a_fetch_valid); end
    checks++; if (a_running !== 1'b0 || a_load_ready !== 1'b1 || a_prog_len !== 17'd0) begin
      errors++; $display("FAIL clear_state got run=%b rdy=%b len=%0d exp 0 1 0", a_running, a_load_ready, a_prog_len);
    end
    load_a(16'h3333, 1'b0);
    load_a(16'h4444, 1'b1);
    fetch_a(16'd1);
    checks++; if (a_fetch_valid !== 1'b1 || a_fetch_instr !== 16'h4444) begin
      errors++; $display("FAIL clear_reload1 got v=%b i=%h exp v=1 i=4444", a_fetch_valid, a_fetch_instr);
    end
    fetch_a(16'd0);
    checks++; if (a_fetch_instr !== 16'h3333) begin errors++; $display("FAIL clear_reload0 got %h exp 3333", a_fetch_instr); end
    fetch_a(16'd2);
    checks++; if (a_fetch_instr !== 16'h0000 || a_fetch_fault !== 1'b0) begin
      errors++; $display("FAIL stale_hidden got i=%h f=%b exp i=0000 f=0", a_fetch_instr, a_fetch_fault);
    end
  endtask

  task automatic test_depth_limit();
    b_load_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_load_data = 16'h5000 + 16'(i);
      checks++; if (b_load_ready !== (i < 4)) begin
        errors++; $display("FAIL depth_ready_%0d got %b exp %b", i, b_load_ready, (i < 4));
      end
      step();
    end
    b_load_valid = 1'b0;
    checks++; if (b_prog_len !== 17'd4 || b_running !== 1'b1 || b_load_ready !== 1'b0) begin
      errors++; $display("FAIL depth_state got len=%0d run=%b rdy=%b exp 4 1 0", b_prog_len, b_running, b_load_ready);
    end
    fetch_b(16'd3);
    checks++; if (b_fetch_valid !== 1'b1 || b_fetch_instr !== 16'h5003 || b_fetch_fault !== 1'b0) begin
      errors++; $display("FAIL depth_word3 got v=%b i=%h f=%b exp v=1 i=5003 f=0", b_fetch_valid, b_fetch_instr, b_fetch_fault);
    end
    fetch_b(16'd0);
    checks++; if (b_fetch_instr !== 16'h5000) begin errors++; $display("FAIL depth_word0 got %h exp 5000", b_fetch_instr); end
    fetch_b(16'd4);
    checks++; if (b_fetch_instr !== 16'h0000 || b_fetch_fault !== 1'b1) begin
      errors++; $display("FAIL depth_fault got i=%h f=%b exp i=0000 f=1", b_fetch_instr, b_fetch_fault);
    end
  endtask

  initial begin
    prog[0]  = make_instr(op_ldi, 12'h407);   // 16'hA407
    prog[1]  = 16'hA503;
    prog[2]  = 16'hA600;
    prog[3]  = 16'hB664;
    prog[4]  = 16'hD501;
    prog[5]  = make_instr(op_rep, 12'h404);   // 16'hC404
    prog[6]  = 16'hE006;
    prog[7]  = 16'h8002;
    prog[8]  = 16'hB123;
    prog[9]  = 16'hE001;
    prog[10] = make_instr(op_halt, 12'h000);  // 16'hF000

    test_reset();
    test_load_program();
    test_fetch();
    test_range();
    test_back_to_back();
    test_reset_mid_load();
    test_clear();
    test_depth_limit();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning instruction word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning fetch address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 1024, meaning the number of storage words (2 <= DEPTH <= 2^ADDR_W).
REQ-004 The block SHALL have parameter NOP_WORD, default 0, meaning the word returned for unprogrammed or invalid addresses.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset; the clock and reset ports are the first two ports.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 The block SHALL have port load_valid, input, 1 bit: a loader word is present.
REQ-009 The block SHALL have port load_data, input, DATA_W bits: the loader word.
REQ-010 The block SHALL have port load_last, input, 1 bit: qualifies the final loader word.
REQ-011 The block SHALL have port load_ready, output, 1 bit: the block accepts a loader word this cycle.
REQ-012 The block SHALL have port load_clear, input, 1 bit: discard the program and return to EMPTY.
REQ-013 The block SHALL have port fetch_req, input, 1 bit: fetch request.
REQ-014 The block SHALL have port fetch_addr, input, ADDR_W bits: fetch word address.
REQ-015 The block SHALL have port fetch_valid, output, 1 bit: fetch_instr and fetch_fault are valid.
REQ-016 The block SHALL have port fetch_instr, output, DATA_W bits: the fetched instruction.
REQ-017 The block SHALL have port fetch_fault, output, 1 bit: the fetched address was >= DEPTH.
REQ-018 The block SHALL have port running, output, 1 bit: high while the state is RUN.
REQ-019 The block SHALL have port prog_len, output, ADDR_W+1 bits: the number of words loaded.

Function
REQ-020 The FSM SHALL have exactly the states EMPTY, LOAD and RUN, with reset entering EMPTY.
REQ-021 load_ready SHALL be 1 in EMPTY and LOAD and 0 in RUN; a word is accepted when load_valid & load_ready.
REQ-022 Each accepted word SHALL be written to mem[wr_ptr], then wr_ptr and prog_len increment; EMPTY->LOAD on the first accepted word, with wr_ptr starting at 0.
REQ-023 An accepted word with load_last=1 SHALL move the state to RUN in the next cycle, with that word included in prog_len.
REQ-024 Acceptance of the word at address DEPTH-1 SHALL force LOAD->RUN regardless of load_last; no write ever exceeds DEPTH-1 (no wrap-around).
REQ-025 A load_last on the first word (EMPTY) SHALL move the state directly to RUN with prog_len=1.
REQ-026 In RUN, fetch_req SHALL produce fetch_valid=1 exactly one cycle later (registered read, latency 1), with one fetch per cycle and no backpressure.
REQ-027 For fetch_addr < prog_len, fetch_instr SHALL be mem[fetch_addr] and fetch_fault=0.
REQ-028 For prog_len <= fetch_addr < DEPTH, fetch_instr SHALL be NOP_WORD and fetch_fault=0.
REQ-029 For fetch_addr >= DEPTH, fetch_instr SHALL be NOP_WORD and fetch_fault=1.
REQ-030 fetch_req outside RUN SHALL be ignored, leaving fetch_valid=0 the next cycle.
REQ-031 fetch_valid SHALL be 0 in any cycle not following an accepted fetch; fetch_instr SHALL hold its last value and fetch_fault SHALL be 0 when fetch_valid=0.
REQ-032 load_clear in any state SHALL set the state to EMPTY and zero wr_ptr and prog_len next cycle, with memory contents unchanged.
REQ-033 When load_clear coincides with load_valid or fetch_req, load_clear SHALL win: no write, and no fetch_valid next cycle.
REQ-034 A fetch accepted in the same cycle that LOAD->RUN is decided SHALL NOT exist, because fetch is gated on the registered state.

Reset
REQ-035 rst=1 SHALL asynchronously force state=EMPTY, wr_ptr=0, prog_len=0, fetch_valid=0, fetch_instr=NOP_WORD, fetch_fault=0, running=0 and load_ready=1 after release.
REQ-036 Storage SHALL NOT be reset; stale contents are unreachable because prog_len=0 maps all reads to NOP_WORD.
REQ-037 Reset asserted mid-load or mid-fetch SHALL abort the operation: the partial program is discarded and no fetch_valid follows.

Structure
REQ-038 State encodings, the default NOP_WORD and the opcode field constants (ldi, jump, out, halt, rep, add, sub) SHALL reside in a shared package/include used by core and bench.
REQ-039 Storage SHALL be one sub-module, pm_ram: a single-port synchronous-write, synchronous-read RAM of DEPTH x DATA_W; the FSM, pointers and range checks SHALL stay in program_memory.

Verification
REQ-040 Load the 11-word multiply program (word0=0xA407, word5=0xC404, load_last on word 10) -> prog_len=11, running=1; fetch 0 -> 0xA407 one cycle later; fetch 5 -> 0xC404.
REQ-041 In RUN, fetch 11 -> 0x0000 with fault=0; fetch DEPTH -> 0x0000 with fault=1; back-to-back fetches 0,1,2 -> three consecutive valid cycles in order.
REQ-042 With DEPTH=4, stream 6 words with no load_last -> 4 accepted, load_ready drops, prog_len=4, and word 3 is readable.
REQ-043 Assert rst after 3 of 11 loader words -> prog_len=0, state EMPTY; fetch_req is ignored; a fresh load restarts at address 0.
REQ-044 In RUN, assert load_clear together with fetch_req -> no fetch_valid, state EMPTY; reloading 2 words makes fetch 1 return the new word.
REQ-045 Assert fetch_req during LOAD -> fetch_valid stays 0 and load continues unaffected.
